// File: rtl/bcd5421_to_8421_seq.sv
// Digit-serial 5421 -> 8421 BCD converter: one word per handshake, one digit per clock.
// Optional illegal-code detection is enabled by defining BCD5421_ERR_CHECK_EN.
module bcd5421_to_8421_seq #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned CW     = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  err,
  output logic [CW-1:0]         err_pos
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   sh_q, sh_d;
  logic [4*DIGITS-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            code;
  logic [3:0]            dec;
  logic [3:0]            nib;

`ifdef BCD5421_ERR_CHECK_EN
  logic                  err_q, err_d;
  logic [CW-1:0]         err_pos_q, err_pos_d;
  logic                  illegal;
`endif

  // Digit decode: value = 5*c3 + c[2:0]; upper codes wrap mod 16 when unchecked.
  always_comb begin
    code = sh_q[3:0];
    dec  = (code[3] ? 4'd5 : 4'd0) + {1'b0, code[2:0]};
`ifdef BCD5421_ERR_CHECK_EN
    illegal = code[2] & (code[1] | code[0]);
    nib     = illegal ? '0 : dec;
`else
    nib     = dec;
`endif
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
`ifdef BCD5421_ERR_CHECK_EN
    err_d      = err_q;
    err_pos_d  = err_pos_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sh_d       = in_data;
          cnt_d      = '0;
          out_data_d = '0;
`ifdef BCD5421_ERR_CHECK_EN
          err_d      = 1'b0;
          err_pos_d  = '0;
`endif
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          if (cnt_q == CW'(k)) out_data_d[4*k +: 4] = nib;
        end
`ifdef BCD5421_ERR_CHECK_EN
        // Only the first illegal digit of a word is recorded.
        if (illegal && !err_q) begin
          err_d     = 1'b1;
          err_pos_d = cnt_q;
        end
`endif
        sh_d  = sh_q >> 4;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
`ifdef BCD5421_ERR_CHECK_EN
      err_q      <= 1'b0;
      err_pos_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
`ifdef BCD5421_ERR_CHECK_EN
      err_q      <= err_d;
      err_pos_q  <= err_pos_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
`ifdef BCD5421_ERR_CHECK_EN
  assign err       = err_q;
  assign err_pos   = err_pos_q;
`else
  assign err       = 1'b0;
  assign err_pos   = '0;
`endif

endmodule

// File: tb/tb_bcd5421_to_8421_seq.sv
// Scoreboard bench for bcd5421_to_8421_seq: input monitor pushes reference decodes,
// output monitor pops and compares on each out_valid/out_ready handshake.
module tb_bcd5421_to_8421_seq;
  localparam int DIGITS = 8;
  localparam int CW     = $clog2(DIGITS);
  localparam int W      = 4 * DIGITS;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          err;
  logic [CW-1:0] err_pos;

  bcd5421_to_8421_seq #(.DIGITS(DIGITS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .err_pos(err_pos)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic          err;
    logic [CW-1:0] pos;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  exp_t          hd;
  int            cyc = 0;
  int            checks = 0;
  int            passed = 0;
  int            rdy_mode = 1;
  bit            b2b = 0;
  int            b2b_n = 0;
  int            last_hs = 0;
  bit            busy = 0;
  bit            prev_valid = 0;
  logic [W-1:0]  held_data;
  logic          held_err;
  logic [CW-1:0] held_pos;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value = 5*c3 + low three bits; legal iff low three bits <= 4.
  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    e.data = '0;
    e.err  = 1'b0;
    e.pos  = '0;
    e.acc  = 0;
    for (int k = 0; k < DIGITS; k++) begin
      int c;
      int v;
      c = int'(w[4*k +: 4]);
      v = 5 * (c / 8) + (c % 8);
`ifdef BCD5421_ERR_CHECK_EN
      if ((c % 8) > 4) begin
        v = 0;
        if (!e.err) begin
          e.err = 1'b1;
          e.pos = CW'(k);
        end
      end
`endif
      e.data[4*k +: 4] = 4'(v % 16);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] enc_digit_word(input int r, input bit rnd);
    logic [W-1:0] w = '0;
    for (int k = 0; k < DIGITS; k++) begin
      int v;
      v = rnd ? int'($urandom_range(0, 9)) : (k + r) % 10;
      w[4*k +: 4] = (v < 5) ? 4'(v) : 4'(v + 3);
    end
    return w;
  endfunction

  function automatic logic [W-1:0] rand_any();
    logic [W-1:0] w = '0;
    for (int k = 0; k < DIGITS; k++) w[4*k +: 4] = 4'($urandom_range(0, 15));
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_err_pos", 64'(err_pos), 64'd0);
      sb.delete();
      busy = 0;
      prev_valid = 0;
      b2b_n = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!busy));
      if (sb.size() == 0) begin
        check("no_spurious_valid", 64'(out_valid), 64'd0);
      end else if (out_valid) begin
        if (!prev_valid) begin
          check("latency", 64'(cyc - sb[0].acc), 64'(DIGITS));
          held_data = out_data;
          held_err  = err;
          held_pos  = err_pos;
        end else begin
          check("hold_data", 64'(out_data), 64'(held_data));
          check("hold_err", 64'({held_err, held_pos}), 64'({err, err_pos}));
        end
        if (out_ready) begin
          hd = sb.pop_front();
          check("out_data", 64'(out_data), 64'(hd.data));
          check("err", 64'(err), 64'(hd.err));
          check("err_pos", 64'(err_pos), 64'(hd.pos));
          if (b2b) begin
            if (b2b_n > 0) check("b2b_period", 64'(cyc - last_hs), 64'(DIGITS + 2));
            b2b_n++;
          end else begin
            b2b_n = 0;
          end
          last_hs = cyc;
          busy = 0;
        end
      end
      if (in_valid && in_ready) begin
        hd = model(in_data);
        hd.acc = cyc + 1;
        sb.push_back(hd);
        busy = 1;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input bit hold);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 500) begin
        $display("FAIL send_timeout: in_ready never rose (cycle %0d)", cyc);
        $fatal(1, "send timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        $display("FAIL drain_timeout: %0d words outstanding (cycle %0d)", sb.size(), cyc);
        $fatal(1, "drain timeout");
      end
    end
    step(1);
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);

    send(32'hCBA9_8432, 0);
    drain();

    for (int r = 0; r < 10; r++) send(enc_digit_word(r, 0), 0);
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send(enc_digit_word(0, 1), 0);
      step($urandom_range(0, 3));
    end
    rdy_mode = 1;
    drain();

    rdy_mode = 0;
    send(enc_digit_word(0, 1), 0);
    in_valid = 1'b1;
    in_data  = enc_digit_word(3, 0);
    step(DIGITS + 20);
    rdy_mode = 1;
    send(enc_digit_word(3, 0), 0);
    drain();

    send(32'hCF94_6832, 0);
    for (int i = 0; i < 10; i++) send(rand_any(), 0);
    drain();

    send(enc_digit_word(0, 1), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(15);
    send(enc_digit_word(7, 0), 0);
    drain();

    b2b = 1;
    for (int i = 0; i < 10; i++) send(enc_digit_word(0, 1), 1);
    in_valid = 1'b0;
    drain();
    b2b = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd5421_to_8421_seq.md
# bcd5421_to_8421_seq

Digit-serial converter from packed 5421-coded decimal words back to 8421 BCD. It is the return path of the 8421→5421 encoding used on the multiplier's operand side. Product digits leave the 5421-domain partial-product array and must be presented to downstream BCD logic. The block accepts one multi-digit word per valid/ready handshake, decodes one digit per clock, and holds the result until it is taken.

## Interface
- DIGITS, default 8: number of decimal digits per word; legal range 2..16.
- CW, default $clog2(DIGITS): width of the digit counter and of `err_pos`.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  4*DIGITS  5421 word; digit k is `[4k+3:4k]`, digit 0 is least significant.
- out_valid  output  1  `out_data` is valid and stable.
- out_ready  input  1  consumer accepts `out_data`.
- out_data  output  4*DIGITS  8421 BCD word, same digit order.
- err  output  1  at least one input digit was an illegal 5421 code.
- err_pos  output  CW  index of the lowest-numbered illegal digit; 0 when `err`=0.

## Operation
- Per-digit decode of code c3c2c1c0: value = 5·c3 + {c2,c1,c0}.
  - Legal codes are 0000–0100 (0–4) and 1000–1100 (5–9).
  - Illegal codes are 0101, 0110, 0111, 1101, 1110, 1111.
- FSM has three states: IDLE, CONV, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `in_data` into a shift register, clear the counter, `err`, `err_pos` and `out_data`, then go to CONV.
- CONV
  - `in_ready`=0.
  - Each cycle, decode shift-register digit 0 and write it into `out_data` at position `cnt`.
  - Shift the register right by 4 and increment `cnt`.
  - When `cnt`==DIGITS-1, go to DONE on the same edge.
- DONE
  - `out_valid`=1; `out_data`, `err` and `err_pos` are held stable.
  - On `out_ready`, return to IDLE.
  - There is no bypass: a new word is not accepted in the cycle that DONE exits.
- `in_data` is ignored outside IDLE.
- `out_ready` is ignored outside DONE.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `err`=0, `err_pos`=0, counter=0.
- Latency: input accepted at edge T gives `out_valid` high after edge T+DIGITS.
- Throughput: one word per DIGITS+2 cycles when `out_ready` is held at 1.
- `out_valid` stays high until sampled with `out_ready`; outputs must not change while it is high.
- `out_data` bits are undefined to the consumer while `out_valid`=0. They are nonetheless registered, and only change in CONV.
- `err_pos` records only the first illegal digit. Later illegal digits in the same word set nothing further.
- Reset asserted mid-CONV or mid-DONE:
  - all state returns to reset values immediately;
  - the word in flight is discarded;
  - no `out_valid` pulse occurs.

## Configuration
- BCD5421_ERR_CHECK_EN defined:
  - illegal codes set `err` and `err_pos` as described above;
  - the offending digit's `out_data` nibble is forced to 0000.
- BCD5421_ERR_CHECK_EN undefined:
  - `err` and `err_pos` are tied to 0;
  - every code decodes arithmetically as (5·c3 + {c2,c1,c0}) mod 16, e.g. 0111→0111, 1111→1100;
  - no error logic is synthesised.

## Test plan
- Reset and single word: DIGITS=8, `in_data`=32'hCBA9_8432 (5421 for 98765432), `out_ready`=1 → `out_valid` rises 8 cycles after acceptance; `out_data`=32'h9876_5432, `err`=0.
- All legal codes: stream words covering digits 0–9 in every position → each `out_data` equals the reference decode. Check `in_ready`=0 throughout CONV and DONE.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → `out_data` is stable and `in_ready`=0 with a new `in_valid` pending; release → IDLE, then the next word is accepted.
- Illegal codes (macro on): digit 3=0110 and digit 6=1111, all other digits legal → `err`=1, `err_pos`=3, nibbles 3 and 6 = 0000. With the macro off the same word gives `err`=0, nibble 3=0110 and nibble 6=1100.
- Reset mid-conversion: assert `rst_n`=0 at CONV cycle 4 → all outputs are at reset values asynchronously; after release, no `out_valid` appears until a new word is accepted.
- Back-to-back: `in_valid`=1 and `out_ready`=1 continuously for 10 words → exactly 10 `out_valid` handshakes, one every DIGITS+2 cycles, with data in order.
